// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master: FSM state encoding, bit-counter
// operation codes and default frame geometry.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_e;

  typedef enum logic [1:0] {
    CNT_CLR  = 2'b00,
    CNT_HOLD = 2'b01,
    CNT_INC  = 2'b10
  } cnt_op_e;

  localparam int DEF_DW  = 8;
  localparam int DEF_DIV = 4;

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer for the SPI master: counts 0..DIV-1 and flags the last cycle
// of each half SCLK period. Held at 0 while clr_i is high.
module spi_phase_timer #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int            PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: shifts one DW-bit frame out on mosi_o MSB first while
// capturing miso_i on each SCLK rise; all outputs are registered.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int DIV = DEF_DIV
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] data_i,
  input  logic          miso_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] data_o,
  output logic          cs_o,
  output logic          sclk_o,
  output logic          mosi_o
);

  localparam int            CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

  spi_state_e    state_q, state_d;
  cnt_op_e       cnt_op;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] tx_q, tx_d, rx_q, rx_d, data_q, data_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d, done_q, done_d, cs_q, cs_d;
  logic          sclk_q, sclk_d, mosi_q, mosi_d;
  logic          tick, timer_clr;
  logic          accept, enter_high, enter_low, enter_done;

  assign timer_clr = (state_q == ST_IDLE) || (state_q == ST_DONE);

  spi_phase_timer #(.DIV(DIV)) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (timer_clr),
    .tick_o (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // last_q remembers that the final bit was reached at LOW entry, so the
  // frame ends after that bit's LOW phase rather than one bit early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_SETUP;
      ST_SETUP: if (tick)    state_d = ST_HIGH;
      ST_HIGH:  if (tick)    state_d = ST_LOW;
      ST_LOW:   if (tick)    state_d = last_q ? ST_DONE : ST_HIGH;
      ST_DONE:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  assign accept     = (state_q == ST_IDLE) && start_i;
  assign enter_high = (state_d == ST_HIGH) && (state_q != ST_HIGH);
  assign enter_low  = (state_d == ST_LOW)  && (state_q != ST_LOW);
  assign enter_done = (state_d == ST_DONE) && (state_q != ST_DONE);

  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    last_d = last_q;
    cnt_op = (state_q == ST_IDLE) ? CNT_CLR : CNT_HOLD;
    busy_d = (state_d != ST_IDLE);
    done_d = 1'b0;
    data_d = data_q;
    cs_d   = cs_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    if (accept) begin
      tx_d   = data_i;
      cs_d   = 1'b0;
      mosi_d = data_i[DW-1];
      last_d = 1'b0;
    end
    if (enter_high) begin
      sclk_d = 1'b1;
      rx_d   = {rx_q[DW-2:0], miso_i};
    end
    if (enter_low) begin
      sclk_d = 1'b0;
      if (cnt_q == LAST_BIT) begin
        last_d = 1'b1;
      end else begin
        tx_d   = tx_q << 1;
        mosi_d = tx_q[DW-2];
        cnt_op = CNT_INC;
      end
    end
    if (enter_done) begin
      cs_d   = 1'b1;
      done_d = 1'b1;
      data_d = rx_q;
      mosi_d = 1'b0;
    end
  end

  always_comb begin
    case (cnt_op)
      CNT_CLR: cnt_d = '0;
      CNT_INC: cnt_d = cnt_q + 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      cs_q   <= 1'b1;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
      data_q <= data_d;
      cs_q   <= cs_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign data_o = data_q;
  assign cs_o   = cs_q;
  assign sclk_o = sclk_q;
  assign mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl: default geometry instance plus a
// DW=16 / DIV=2 instance, observed on the falling clock edge.
module tb_spi_master_ctrl;

  localparam int DW   = 8;
  localparam int DIV  = 4;
  localparam int DW2  = 16;
  localparam int DIV2 = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          start, miso_drv, loop_en, miso;
  logic [DW-1:0] din, dout;
  logic          busy, done, cs, sclk, mosi;
  assign miso = loop_en ? mosi : miso_drv;

  logic           s_start, s_busy, s_done, s_cs, s_sclk, s_mosi;
  logic [DW2-1:0] s_din, s_dout;

  spi_master_ctrl #(.DW(DW), .DIV(DIV)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .data_i(din), .miso_i(miso),
    .busy_o(busy), .done_o(done), .data_o(dout), .cs_o(cs), .sclk_o(sclk),
    .mosi_o(mosi)
  );

  spi_master_ctrl #(.DW(DW2), .DIV(DIV2)) dut_min (
    .clk_i(clk), .rst_i(rst), .start_i(s_start), .data_i(s_din), .miso_i(s_mosi),
    .busy_o(s_busy), .done_o(s_done), .data_o(s_dout), .cs_o(s_cs),
    .sclk_o(s_sclk), .mosi_o(s_mosi)
  );

  // scoreboard
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Observes one frame starting at the first falling edge after acceptance.
  // The model records mosi/miso at each SCLK rise and predicts data_o from it.
  task automatic monitor_frame(input logic [DW-1:0] tx, input int mode, input bit poke);
    logic [DW-1:0] tx_seen, rx_model;
    int rises, hi, cs_low, first_rise, t;
    bit prev_sclk, got_done;
    tx_seen = '0; rx_model = '0; rises = 0; hi = 0; cs_low = 0;
    first_rise = 0; t = 1; prev_sclk = 1'b0; got_done = 1'b0;
    check("start_busy", busy, 1);
    check("start_cs", cs, 0);
    check("start_mosi", mosi, tx[DW-1]);
    while (!got_done && t < 400) begin
      if (poke) start = 1'b0;
      if (!cs) cs_low++;
      if (sclk) hi++;
      if (sclk && !prev_sclk) begin
        rises++;
        if (rises == 1) first_rise = t;
        tx_seen  = {tx_seen[DW-2:0], mosi};
        rx_model = {rx_model[DW-2:0], miso};
        if (poke && rises == 4) begin start = 1'b1; din = '1; end
      end
      if (done) begin
        got_done = 1'b1;
        exp_q.push_back(rx_model);
        check("done_time", t, 1 + (2*DW+1)*DIV);
        check("done_cs", cs, 1);
        check("done_busy", busy, 1);
        check("done_mosi", mosi, 0);
        check("data_o", dout, exp_q.pop_front());
        if (poke) begin start = 1'b1; din = '1; end
      end
      prev_sclk = sclk;
      if (!got_done) begin
        if (mode == 2) miso_drv = 1'($urandom);
        @(negedge clk);
        t++;
      end
    end
    if (!got_done) check("frame_timeout", 0, 1);
    check("sclk_rises", rises, DW);
    check("sclk_high_cycles", hi, DW*DIV);
    check("cs_low_cycles", cs_low, (2*DW+1)*DIV);
    check("first_rise", first_rise, 1 + DIV);
    check("tx_bits", tx_seen, tx);
  endtask

  task automatic send(input logic [DW-1:0] tx, input int mode, input bit poke);
    @(negedge clk);
    start = 1'b1;
    din   = tx;
    if (mode == 1) miso_drv = 1'b1;
    @(negedge clk);
    start = 1'b0;
    din   = DW'($urandom);
    monitor_frame(tx, mode, poke);
  endtask

  task automatic finish_idle();
    @(negedge clk);
    start = 1'b0;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_cs", cs, 1);
    check("post_sclk", sclk, 0);
    check("post_mosi", mosi, 0);
  endtask

  initial begin
    int cs_high, r, guard, s_low, s_rises;
    bit prev;
    logic [DW-1:0] last_dout;
    rst = 1'b1; start = 1'b0; din = '0; miso_drv = 1'b0; loop_en = 1'b0;
    s_start = 1'b0; s_din = '0;

    // reset held 3 cycles with random inputs
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom); din = DW'($urandom); miso_drv = 1'($urandom);
      s_start = 1'($urandom); s_din = DW2'($urandom);
    end
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", dout, 0);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_min_cs", s_cs, 1);
    check("rst_min_busy", s_busy, 0);
    start = 1'b0; s_start = 1'b0; rst = 1'b0;

    // loopback 0xA5
    loop_en = 1'b1;
    send(8'hA5, 0, 1'b0);
    check("loop_data", dout, 8'hA5);
    finish_idle();

    // starts during the frame and in DONE are ignored
    loop_en = 1'b0;
    send(8'h3C, 1, 1'b1);
    check("ign_data", dout, 8'hFF);
    finish_idle();
    repeat (3*DIV) @(negedge clk);
    check("no_second_busy", busy, 0);
    check("no_second_cs", cs, 1);

    // back-to-back with start held high
    loop_en = 1'b1;
    @(negedge clk); start = 1'b1; din = 8'h81;
    @(negedge clk); din = 8'h7E;
    monitor_frame(8'h81, 0, 1'b0);
    cs_high = 1;
    @(negedge clk);
    check("b2b_idle_busy", busy, 0);
    if (cs) cs_high++;
    @(negedge clk);
    start = 1'b0;
    if (cs) cs_high++;
    check("b2b_gap", cs_high, 2);
    monitor_frame(8'h7E, 0, 1'b0);
    finish_idle();

    // random words with random miso
    loop_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(DW'($urandom_range(0, 255)), 2, 1'b0);
      finish_idle();
    end

    // reset after the 4th rise
    loop_en = 1'b1;
    last_dout = dout;
    check("pre_rst_data_kept", dout, last_dout);
    @(negedge clk); start = 1'b1; din = 8'hC3;
    @(negedge clk); start = 1'b0;
    r = 0; prev = 1'b0; guard = 0;
    while (r < 4 && guard < 200) begin
      if (sclk && !prev) r++;
      prev = sclk;
      if (r < 4) begin @(negedge clk); guard++; end
    end
    check("rst_mid_reached", r, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_cs", cs, 1);
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_data", dout, 0);
    check("rst_mid_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_no_done", done, 0);
    end
    send(8'h5A, 0, 1'b0);
    check("rst_recover_data", dout, 8'h5A);
    finish_idle();

    // minimum divider, wide frame, loopback
    @(negedge clk); s_start = 1'b1; s_din = 16'hBEEF;
    @(negedge clk); s_start = 1'b0;
    s_low = 0; s_rises = 0; prev = 1'b0; guard = 0;
    while (!s_done && guard < 400) begin
      if (!s_cs) s_low++;
      if (s_sclk && !prev) s_rises++;
      prev = s_sclk;
      @(negedge clk);
      guard++;
    end
    check("min_done", s_done, 1);
    check("min_cs_low", s_low, (2*DW2+1)*DIV2);
    check("min_rises", s_rises, DW2);
    check("min_data", s_dout, 16'hBEEF);
    @(negedge clk);
    check("min_post_busy", s_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
